// File: rtl/axis_rr_scalar_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axis_rr_scalar_arbiter
// Description : Round-robin arbiter sharing one scalar filter input between
//               NUM_CH AXI-Stream sources. One source is granted at a time;
//               accepted beats are presented as a registered data_out /
//               data_valid pair tagged with the source index.
//               Optional build macro: ARB_PKT_LOCK_EN -- hold the grant for a
//               whole packet (release only on an accepted s_tlast beat).
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_scalar_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic [2:0]               data_ch,
  output logic                     data_last,
  output logic                     busy
);

  localparam int                CH_W     = $clog2(NUM_CH);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);
`ifndef ARB_PKT_LOCK_EN
  localparam logic [7:0]        LAST_BEAT = 8'(MAX_BURST - 1);
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic [2:0]          data_ch_q, data_ch_d;
  logic                data_last_q, data_last_d;

  logic                sel_found;
  logic [CH_W-1:0]     sel_idx;
  logic [CH_W:0]       cand;
  logic                rel_now;

  // Per-channel view of the flat data bus so the granted beat is a simple index.
  logic [DATA_W-1:0]   ch_data [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = s_tdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: first valid channel scanning ptr, ptr+1, ... modulo NUM_CH.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (cand >= NUM_CH_L) begin
        cand = cand - NUM_CH_L;
      end
      if (!sel_found && s_tvalid[cand[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[CH_W-1:0];
      end
    end
  end

  // Next-state logic: grant in IDLE, drain beats and decide release in GRANT.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    beat_cnt_d   = beat_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_ch_d    = data_ch_q;
    data_last_d  = data_last_q;
    rel_now      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && sel_found) begin
          gnt_d      = sel_idx;
          beat_cnt_d = 8'd0;
          state_d    = GRANT;
        end
      end

      GRANT: begin
        if (s_tvalid[gnt_q]) begin
          data_out_d   = ch_data[gnt_q];
          data_valid_d = 1'b1;
          data_ch_d    = 3'(gnt_q);
          data_last_d  = s_tlast[gnt_q];
`ifdef ARB_PKT_LOCK_EN
          // Packet-atomic: only the end-of-packet beat ends the grant.
          beat_cnt_d   = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
          rel_now      = s_tlast[gnt_q];
`else
          // The beat that completes the burst is still accepted.
          beat_cnt_d   = beat_cnt_q + 8'd1;
          rel_now      = (beat_cnt_q == LAST_BEAT);
`endif
        end else begin
`ifndef ARB_PKT_LOCK_EN
          // A gap in the granted stream hands the datapath to the others.
          rel_now = 1'b1;
`endif
        end

        if (rel_now) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == LAST_CH) ? '0 : gnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      ptr_q        <= '0;
      beat_cnt_q   <= 8'd0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_ch_q    <= 3'd0;
      data_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_ch_q    <= data_ch_d;
      data_last_q  <= data_last_d;
    end
  end

  // Ready is decoded from registered state only, so it never depends on s_tvalid.
  always_comb begin
    s_tready = '0;
    if (state_q == GRANT) begin
      s_tready[gnt_q] = 1'b1;
    end
  end

  assign busy       = (state_q == GRANT);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_ch    = data_ch_q;
  assign data_last  = data_last_q;

endmodule
`default_nettype wire

// File: doc/axis_rr_scalar_arbiter.md
# axis_rr_scalar_arbiter

Round-robin scheduler that shares one scalar filter datapath (FIR/CIC/Sobel input port) between several AXI-Stream sources. It grants one source at a time, drains beats from it as a registered `data_out`/`data_valid` scalar pair tagged with the source index, and re-arbitrates on burst limit or input gap. It sits between the DMA/stream front-ends and the filter's scalar input.

## Interface
- `NUM_CH`, 4: number of stream sources, 2..8.
- `DATA_W`, 16: beat width.
- `MAX_BURST`, 8: maximum beats per grant, 1..255.

- `clk`  in  1  single clock, all logic rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new grants; does not abort a grant in progress.
- `s_tdata`  in  NUM_CH*DATA_W  source data, channel i at bits [i*DATA_W +: DATA_W].
- `s_tvalid`  in  NUM_CH  per-source valid.
- `s_tlast`  in  NUM_CH  per-source end-of-packet.
- `s_tready`  out  NUM_CH  per-source ready; at most one bit high.
- `data_out`  out  DATA_W  registered beat data.
- `data_valid`  out  1  one-cycle pulse per accepted beat.
- `data_ch`  out  3  source index of current `data_out`.
- `data_last`  out  1  `s_tlast` of the accepted beat.
- `busy`  out  1  high while in GRANT.

## Operation
- FSM states: IDLE, GRANT. Registers: `gnt` (index), `ptr` (round-robin start), `beat_cnt` (8 bit).
- IDLE: if `enable` and any `s_tvalid`, select the first asserted channel scanning `ptr`, `ptr+1`, … mod NUM_CH; load `gnt`, clear `beat_cnt`, go to GRANT. `s_tready` all zero in IDLE.
- GRANT: `s_tready[gnt]` = 1 (decoded from registered state, not from `s_tvalid`). On a cycle with `s_tvalid[gnt]`: capture beat into outputs, `beat_cnt++`.
- Release (GRANT→IDLE, `ptr <= (gnt+1) mod NUM_CH`) on the first of:
  - accepted beat is the MAX_BURST-th of the grant;
  - a GRANT cycle with `s_tvalid[gnt]` low (gap).
- Release beat is accepted; `s_tready` drops the following cycle.
- No beat accepted in a cycle: `data_valid <= 0`; `data_out`, `data_ch`, `data_last` hold.
- `enable` low during GRANT: grant continues until a release condition; IDLE then stays idle.
- Reset (any time, including mid-grant): state IDLE, `ptr` 0, `gnt` 0, `beat_cnt` 0, `data_out` 0, `data_valid` 0, `data_ch` 0, `data_last` 0; `s_tready` and `busy` 0 immediately (async).

## Timing
- `s_tvalid` seen in IDLE at cycle N → `s_tready[gnt]` high in N+1 → first `data_valid` in N+2 (if beat offered at N+1).
- Sustained throughput within a grant: 1 beat/cycle.
- One dead cycle (IDLE) between consecutive grants; MAX_BURST=B gives B/(B+1) peak utilisation.
- Channel change visible on `data_ch` the same cycle as its first `data_valid`.
- Sources must hold data stable while `s_tvalid` high and `s_tready` low (AXI-Stream rule); arbiter never asserts `s_tready` to a non-granted channel.

## Configuration
- `ARB_PKT_LOCK_EN` defined: grant held for a whole packet — release only on accepted beat with `s_tlast[gnt]`; MAX_BURST limit and gap release disabled; `beat_cnt` saturates at 255. A source that never asserts `s_tlast` owns the datapath indefinitely (by design, for packet-atomic Sobel lines).
- Not defined: release rules as in Operation; `s_tlast` only forwarded to `data_last`.

## Test plan
- Reset: assert `resetn`=0 mid-grant with ch1 streaming → all outputs 0 and `s_tready`=0 same cycle; after release, first grant scans from ch0.
- Single source: ch2 offers 0x0011,0x0022,0x0033 back-to-back, MAX_BURST=8 → `data_valid` 3 cycles, `data_ch`=2, data in order, release on gap, `ptr`=3.
- Burst limit: ch0 and ch1 continuously valid, MAX_BURST=4 → output pattern 4×ch0, 1 dead cycle, 4×ch1, dead, 4×ch0…
- Fairness: all 4 channels continuously valid, MAX_BURST=1 → `data_ch` sequence 0,1,2,3,0… each separated by one idle cycle.
- Enable: `enable` dropped during ch3 grant after beat 2 of 8 → remaining 6 beats delivered, then `busy`=0, no new grant while `enable`=0 despite pending ch0.
- `ARB_PKT_LOCK_EN` build: ch1 sends 12-beat packet with a 2-cycle gap, ch0 pending, MAX_BURST=4 → all 12 ch1 beats before any ch0 beat, `data_last`=1 on beat 12 only.
